// File: rtl/window_pkg.sv
// window_pkg: shared defaults, FSM state type and output-dimension helper for the window generator
package window_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DIM_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int out_dim(input int d, input int k, input logic pad, input logic s2);
    if (pad) return s2 ? (d + 1) / 2 : d;
    if (d < k) return 0;
    return (s2 ? (d - k) / 2 : d - k) + 1;
  endfunction
endpackage

// File: rtl/kxk_line_store.sv
// kxk_line_store: K-row circular pixel store with KxK combinational taps, zero-pad masking and write-through
module kxk_line_store import window_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W = DEF_DIM_W,
  parameter int MAX_WIDTH = 256,
  parameter int K = 3,
  localparam int AW = $clog2(MAX_WIDTH),
  localparam int SW = $clog2(K)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [SW-1:0]            wslot,
  input  logic [AW-1:0]            wx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic signed [DIM_W+1:0]  y0,
  input  logic signed [DIM_W+1:0]  x0,
  input  logic [DIM_W-1:0]         h,
  input  logic [DIM_W-1:0]         w,
  output logic [K*K*DATA_W-1:0]    win
);
  logic [DATA_W-1:0] mem [K][MAX_WIDTH];
  // pixel (y,x) lands in row slot y mod K, column x
  always_ff @(posedge clk)
    if (we) mem[wslot][wx] <= wdata;
  for (genvar i = 0; i < K; i++) begin : g_r
    for (genvar j = 0; j < K; j++) begin : g_c
      logic signed [DIM_W+1:0] yy, xx;
      logic [SW-1:0] sl;
      logic [AW-1:0] xa;
      logic oob;
      assign yy = y0 + (DIM_W+2)'(i);
      assign xx = x0 + (DIM_W+2)'(j);
      assign oob = yy < 0 || xx < 0 || yy >= $signed({2'b0, h}) || xx >= $signed({2'b0, w});
      assign sl = SW'(32'(yy[DIM_W:0]) % K);
      assign xa = AW'(xx);
      assign win[(i*K+j)*DATA_W +: DATA_W] = oob ? '0 : (we && wslot == sl && wx == xa) ? wdata : mem[sl][xa];
    end
  end
endmodule

// File: rtl/window_gen_kxk_stream.sv
// window_gen_kxk_stream: streaming KxK sliding-window generator with padding, stride 1/2 and backpressure
module window_gen_kxk_stream import window_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W = DEF_DIM_W,
  parameter int MAX_WIDTH = 256,
  parameter int K = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DIM_W-1:0]       cfg_width,
  input  logic [DIM_W-1:0]       cfg_height,
  input  logic                   cfg_pad,
  input  logic                   cfg_stride2,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [K*K*DATA_W-1:0]  out_win,
  output logic [DIM_W-1:0]       out_row,
  output logic [DIM_W-1:0]       out_col,
  output logic                   out_last
);
  localparam int P = (K - 1) / 2;
  localparam int SW = $clog2(K);
  localparam int CW = 2 * DIM_W;
  localparam int SX = DIM_W + 2;
  state_t state, nxt;
  logic [DIM_W-1:0] h, w, hout, wout, r, c, in_x, in_y, hn, wn;
  logic pad, s2;
  logic [CW-1:0] in_count, hw, idx, cnt_n;
  logic [SW-1:0] in_slot;
  logic [SX-1:0] ro, co, po;
  logic signed [SX-1:0] y0, x0, ye, xe, ym, xm;
  logic [K*K*DATA_W-1:0] taps;
  logic in_fire, load, last_hs, win_rdy;
  assign hn = DIM_W'(out_dim(int'(cfg_height), K, cfg_pad, cfg_stride2));
  assign wn = DIM_W'(out_dim(int'(cfg_width), K, cfg_pad, cfg_stride2));
  assign hw = CW'(h) * CW'(w);
  assign po = pad ? SX'(P) : '0;
  assign ro = {2'b0, r} << s2;
  assign co = {2'b0, c} << s2;
  assign y0 = $signed(ro - po);
  assign x0 = $signed(co - po);
  assign ye = y0 + SX'(K - 1);
  assign xe = x0 + SX'(K - 1);
  assign ym = ye >= $signed({2'b0, h}) ? $signed({2'b0, h}) - SX'(1) : ye;
  assign xm = xe >= $signed({2'b0, w}) ? $signed({2'b0, w}) - SX'(1) : xe;
  assign idx = CW'(ym) * CW'(w) + CW'(xm);
  assign cnt_n = in_count + CW'(in_fire);
  assign in_ready = state == RUN && in_count < hw && $signed({2'b0, in_y}) < y0 + SX'(K);
  assign in_fire = in_valid && in_ready;
  assign win_rdy = state == RUN && r != hout && cnt_n > idx;
  assign load = win_rdy && (!out_valid || out_ready);
  assign last_hs = out_valid && out_ready && out_last;
  assign busy = state != IDLE;
  assign done = state == DONE;
  kxk_line_store #(.DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_WIDTH(MAX_WIDTH), .K(K)) u_store (
    .clk(clk), .we(in_fire), .wslot(in_slot), .wx($clog2(MAX_WIDTH)'(in_x)), .wdata(in_data),
    .y0(y0), .x0(x0), .h(h), .w(w), .win(taps)
  );
  // frame state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // empty output maps skip straight to DONE; RUN ends on the last window handshake
  always_comb begin
    nxt = state;
    if (state == IDLE && start) nxt = (hn == '0 || wn == '0) ? DONE : RUN;
    else if (state == RUN && last_hs) nxt = DONE;
    else if (state == DONE) nxt = IDLE;
  end
  // config latch, input raster counters, output coordinates and the output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {h, w, hout, wout, pad, s2} <= '0;
      {in_count, in_x, in_y, in_slot, r, c} <= '0;
      {out_valid, out_win, out_row, out_col, out_last} <= '0;
    end else begin
      if (state == IDLE && start) begin
        {h, w, pad, s2, hout, wout} <= {cfg_height, cfg_width, cfg_pad, cfg_stride2, hn, wn};
        {in_count, in_x, in_y, in_slot, r, c} <= '0;
      end
      if (in_fire) begin
        in_count <= in_count + 1'b1;
        in_x <= in_x == w - 1'b1 ? '0 : in_x + 1'b1;
        if (in_x == w - 1'b1) begin
          in_y <= in_y + 1'b1;
          in_slot <= in_slot == SW'(K - 1) ? '0 : in_slot + 1'b1;
        end
      end
      if (load) begin
        out_win <= taps;
        out_row <= r;
        out_col <= c;
        out_last <= r == hout - 1'b1 && c == wout - 1'b1;
        c <= c == wout - 1'b1 ? '0 : c + 1'b1;
        if (c == wout - 1'b1) r <= r + 1'b1;
      end
      out_valid <= load || (out_valid && !out_ready);
    end
endmodule

// File: tb/tb_window_gen_kxk_stream.sv
// tb_window_gen_kxk_stream: directed frames with hand-computed windows plus a reference window model
module tb_window_gen_kxk_stream;
  localparam int DATA_W = 16;
  localparam int DIM_W = 8;
  localparam int K = 3;
  localparam int WW = K * K * DATA_W;
  logic clk, rst_n, start, cfg_pad, cfg_stride2, busy, done;
  logic [DIM_W-1:0] cfg_width, cfg_height, out_row, out_col;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DATA_W-1:0] in_data;
  logic [WW-1:0] out_win;
  int n_tests, n_fail;
  int done_cyc, last_cyc, st_pix;
  bit st_ir, moved, ir_hi;
  int ev[K*K];
  logic [WW-1:0] qw[$];
  logic [2*DIM_W:0] qc[$];

  window_gen_kxk_stream #(.DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_WIDTH(16), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_pad(cfg_pad), .cfg_stride2(cfg_stride2), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] pk();
    logic [WW-1:0] v;
    for (int n = 0; n < K*K; n++) v[n*DATA_W +: DATA_W] = DATA_W'(ev[n]);
    return v;
  endfunction

  function automatic logic [WW-1:0] mdl(input int h, input int w, input bit pad, input bit s2, input int r, input int c);
    logic [WW-1:0] v;
    int s, p, y, x;
    s = s2 ? 2 : 1;
    p = pad ? (K - 1) / 2 : 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        y = r * s - p + i;
        x = c * s - p + j;
        v[(i*K+j)*DATA_W +: DATA_W] = (y >= 0 && y < h && x >= 0 && x < w) ? DATA_W'(y * w + x + 1) : '0;
      end
    return v;
  endfunction

  function automatic logic [255:0] snap();
    return {busy, done, in_ready, out_valid, out_last, out_row, out_col, out_win};
  endfunction

  task automatic run_frame(input int h, input int w, input bit pad, input bit s2,
                           input int ho, input int wo, input int stall, input int abort);
    int pix, stall_left;
    bit seen_v, stalling;
    logic [WW-1:0] hold;
    qw.delete();
    qc.delete();
    pix = 0; seen_v = 0; stall_left = 0; hold = '0;
    done_cyc = -1; last_cyc = -1; st_pix = -1; st_ir = 1; moved = 0; ir_hi = 0;
    @(negedge clk);
    cfg_height = DIM_W'(h); cfg_width = DIM_W'(w); cfg_pad = pad; cfg_stride2 = s2; start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (out_valid && !seen_v) begin
        seen_v = 1;
        stall_left = stall;
        hold = out_win;
      end
      stalling = stall_left > 0;
      if (stalling && (out_win !== hold || !out_valid)) moved = 1;
      out_ready = !stalling;
      if (stalling) stall_left--;
      in_valid = pix < h * w;
      in_data = DATA_W'(pix + 1);
      #1;
      ir_hi |= in_ready;
      if (stalling) begin
        st_pix = pix;
        st_ir = in_ready;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (in_valid && in_ready) pix++;
      if (out_valid && out_ready) begin
        qw.push_back(out_win);
        qc.push_back({out_row, out_col, out_last});
        if (out_last) last_cyc = cyc;
      end
      if (abort > 0 && pix == abort) break;
      @(negedge clk);
    end
    if (abort > 0) begin
      @(negedge clk);
    end else begin
      in_valid = 0;
      out_ready = 1;
      chk("done_seen", done_cyc >= 0, 1);
      chk("win_count", qw.size(), ho * wo);
      if (ho * wo > 0) chk("done_latency", done_cyc - last_cyc, 1);
      for (int n = 0; n < qw.size() && n < ho * wo; n++) begin
        chk("win_data", qw[n], mdl(h, w, pad, s2, n / wo, n % wo));
        chk("win_coord", qc[n], {DIM_W'(n / wo), DIM_W'(n % wo), n == ho * wo - 1});
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 0; start = 0; cfg_width = 0; cfg_height = 0; cfg_pad = 0; cfg_stride2 = 0;
    in_valid = 0; in_data = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", snap(), 0);
    rst_n = 1;
    run_frame(4, 4, 1, 0, 4, 4, 0, 0);
    ev = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    chk("pad_first", qw[0], pk());
    ev = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
    chk("pad_last", qw[15], pk());
    chk("pad_last_flag", qc[15][0], 1);
    run_frame(4, 4, 0, 0, 2, 2, 0, 0);
    ev = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    chk("valid_00", qw[0], pk());
    ev = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    chk("valid_11", qw[3], pk());
    run_frame(5, 5, 0, 1, 2, 2, 0, 0);
    ev = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    chk("s2_00", qw[0], pk());
    ev = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    chk("s2_11", qw[3], pk());
    run_frame(8, 8, 1, 0, 8, 8, 40, 0);
    chk("stall_hold", moved, 0);
    chk("stall_pixels", st_pix, 16);
    chk("stall_in_ready", st_ir, 0);
    run_frame(2, 8, 0, 0, 0, 0, 0, 0);
    chk("empty_in_ready", ir_hi, 0);
    chk("empty_done_cyc", done_cyc, 0);
    run_frame(4, 4, 1, 0, 4, 4, 0, 0);
    run_frame(4, 4, 1, 0, 4, 4, 0, 10);
    chk("mid_busy", {busy, out_valid}, 2'b11);
    rst_n = 0;
    #1;
    chk("mid_reset", snap(), 0);
    @(negedge clk);
    in_valid = 0;
    rst_n = 1;
    run_frame(4, 4, 1, 0, 4, 4, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
